// File: rtl/std_counter_array.sv
// Bank of independent up/down counters with per-channel step, terminal value,
// load/clear, wrap or saturate behaviour, sticky overflow and optional cascading.
module std_counter_array #(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 4,
    parameter int               SATURATE = 0,
    parameter int               CASCADE  = 0,
    parameter logic [WIDTH-1:0] RESET    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       direction,
    input  logic [CHANNELS*WIDTH-1:0] step,
    input  logic [CHANNELS*WIDTH-1:0] max,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       load_enable,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS*WIDTH-1:0] next_value,
    output logic [CHANNELS-1:0]       complete,
    output logic [CHANNELS-1:0]       overflow
);

    localparam int             VW  = CHANNELS * WIDTH;
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    logic [VW-1:0]       value_r;
    logic [VW-1:0]       next_c;
    logic [CHANNELS-1:0] overflow_r;
    logic [CHANNELS-1:0] overflow_c;
    logic [CHANNELS-1:0] complete_c;

    // One extra bit keeps value + step and value + max + 1 exact before comparing.
    logic [WIDTH:0]   v_x;
    logic [WIDTH:0]   s_x;
    logic [WIDTH:0]   m_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   wrap_x;
    logic [WIDTH-1:0] cnt;
    logic             term;
    logic             en_eff;
    logic             carry;

    always_comb begin
        next_c     = value_r;
        overflow_c = overflow_r;
        complete_c = '0;
        v_x        = '0;
        s_x        = '0;
        m_x        = '0;
        sum_x      = '0;
        wrap_x     = '0;
        cnt        = '0;
        term       = 1'b0;
        en_eff     = 1'b0;
        carry      = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            v_x    = {1'b0, value_r[i*WIDTH +: WIDTH]};
            s_x    = {1'b0, step[i*WIDTH +: WIDTH]};
            m_x    = {1'b0, max[i*WIDTH +: WIDTH]};
            // carry still holds the previous channel's complete here
            en_eff = enable[i] && ((CASCADE == 0) || (i == 0) || carry);
            if (direction[i]) begin
                sum_x  = v_x + s_x;
                term   = (sum_x > m_x) || (v_x > m_x);
                wrap_x = sum_x - m_x - ONE;
                if (!term)
                    cnt = WIDTH'(sum_x);
                else if (SATURATE != 0)
                    cnt = WIDTH'(m_x);
                else if (v_x > m_x)
                    cnt = '0;
                else
                    cnt = WIDTH'(wrap_x);
            end else begin
                sum_x  = v_x - s_x;
                term   = v_x < s_x;
                wrap_x = v_x + m_x + ONE - s_x;
                if (!term)
                    cnt = WIDTH'(sum_x);
                else if (SATURATE != 0)
                    cnt = '0;
                else
                    cnt = WIDTH'(wrap_x);
            end
            complete_c[i] = en_eff && term && !load_enable[i] && !clear[i];
            carry         = complete_c[i];
            if (load_enable[i]) begin
                next_c[i*WIDTH +: WIDTH] = load_value[i*WIDTH +: WIDTH];
                overflow_c[i]            = 1'b0;
            end else if (clear[i]) begin
                next_c[i*WIDTH +: WIDTH] = '0;
                overflow_c[i]            = 1'b0;
            end else begin
                if (en_eff)
                    next_c[i*WIDTH +: WIDTH] = cnt;
                if (complete_c[i])
                    overflow_c[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_r    <= {CHANNELS{RESET}};
            overflow_r <= '0;
        end else begin
            value_r    <= next_c;
            overflow_r <= overflow_c;
        end
    end

    assign value      = value_r;
    assign next_value = next_c;
    assign complete   = complete_c;
    assign overflow   = overflow_r;

endmodule
